fsk_frame_sequencer: RTL
========================

Name: fsk_frame_sequencer

Overview:
- Controller that sequences the FSK modulator datapath: builds a transmit frame (preamble, sync word, payload bytes, optional CRC) and drives the modulator's tone select and enable at a programmable bit rate.
- Sits between the LA/CPU-side byte source and the mbsFSK tone generator inside the wrapped user project.
- Payload bytes arrive on a valid/ready stream with a one-byte holding register, so the CPU can prefetch.

Parameters:
- PREAMBLE_BITS, 16, number of alternating preamble bits; legal range 2..255.
- SYNC_WORD, 16'h2DD4, 16-bit sync pattern sent MSB first after the preamble.
- DIV_W, 16, width of the bit-period divider.

Ports:
- wb_clk_i  input  1  system clock; all logic is on the rising edge.
- wb_rst_n  input  1  asynchronous, active-low reset.
- baud_div  input  DIV_W  bit period = baud_div+1 clocks; latched on an accepted start.
- start  input  1  begin frame; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE.
- data  input  8  payload byte.
- data_last  input  1  marks the final payload byte.
- data_valid  input  1  byte/last qualifier.
- data_ready  output  1  holding register empty and more bytes still expected.
- tx_en  output  1  modulator enable.
- tone_sel  output  1  1 = mark, 0 = space; modulator bit.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on normal frame completion.
- underrun  output  1  one-cycle pulse when the payload starves.

Behaviour:
- Reset (asynchronous, wb_rst_n=0): state IDLE; all outputs 0; holding register empty; counters and CRC register cleared.
- FSM states: IDLE, PREAMBLE, SYNC, PAYLOAD, CRC, plus CRC only with the optional feature.
- **IDLE.** tx_en=0, tone_sel=0, busy=0, data_ready=0. If start=1 and abort=0: latch baud_div, enter PREAMBLE. On the next cycle tx_en=1 and busy=1.
- **Bit timing.** A div counter runs 0..baud_div_latched. Each bit holds tone_sel for exactly baud_div+1 cycles. baud_div=0 gives 1 clock per bit. The bit boundary is where the counter wraps to 0.
- **PREAMBLE.** PREAMBLE_BITS bits alternating, starting with 1 (1,0,1,0,...), then enter SYNC.
- **SYNC.** 16 bits of SYNC_WORD, MSB first, then enter PAYLOAD.
- **PAYLOAD.** Bytes are shifted MSB first. At each byte's final bit boundary:
  - if the holding register is full, load the shift register from it in the same cycle, with no gap;
  - otherwise, if the byte just sent carried last, go to CRC (feature on) or finish;
  - otherwise it is an underrun: pulse underrun, go to IDLE, tx_en=0 next cycle, no done pulse.
- **Holding register.**
  - data_ready=1 in PREAMBLE/SYNC/PAYLOAD while the holder is empty and no byte with data_last has been accepted this frame.
  - A transfer occurs on data_valid & data_ready. A load into the shift register and a new accept may occur in the same cycle.
  - After a last byte is accepted, data_ready stays 0 until the next frame.
  - No byte accepted by the end of SYNC is an underrun.
- **Finish.** On the cycle after the final bit period: IDLE, tx_en=0, busy=0, tone_sel=0, done=1 for one cycle.
  - Frame length N = PREAMBLE_BITS + 16 + 8·bytes (+16 with CRC) bits.
  - tx_en is high for exactly N·(baud_div+1) cycles.
- **Other rules.**
  - start while busy is ignored.
  - abort has priority over every event, including start and bit boundaries: next cycle IDLE, all outputs 0, holder flushed, no done or underrun pulse.
  - abort and a data handshake in the same cycle: the byte is discarded.
  - Reset mid-frame: immediate return to the reset state, including tx_en=0.
  - Changing baud_div mid-frame has no effect.

Optional Feature:
- Macro FSK_SEQ_CRC16_EN.
- **Defined:**
  - A CRC-16/CCITT is computed over payload bits as they are shifted: polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
  - It is reset on start.
  - After the last payload bit, the CRC state sends the 16-bit CRC MSB first, then finishes.
- **Undefined:** no CRC state or logic; PAYLOAD goes straight to finish.

Test Plan:
- baud_div=3, one byte 0xA5 with last, accepted during PREAMBLE, feature off → tone_sel sequence 1010101010101010, 0010110111010100, 10100101, each bit 4 cycles; tx_en high 160 cycles; done pulses once.
- Feature on, baud_div=0, payload "123456789" (0x31..0x39, last on 0x39) → trailing 16 bits equal 0x29B1; tx_en high 120 cycles.
- Two bytes 0x00 and 0xFF with valid held continuously → back-to-back with no gap; data_ready falls after 0xFF/last is accepted and stays 0.
- Two-byte frame with the second byte withheld past the first byte's last bit → underrun pulse, tx_en=0 next cycle, no done, busy=0.
- abort asserted mid-SYNC with start also high → IDLE next cycle, all outputs 0; a subsequent start runs a full clean frame.
- wb_rst_n pulled low mid-PAYLOAD → outputs 0 immediately; start pulsed during busy → ignored, with the frame length unchanged.

Source files
------------

// File: rtl/fsk_frame_sequencer.sv
// FSK frame sequencer: builds preamble, sync word, payload bytes and
// (optionally) a CRC-16/CCITT trailer, and drives the modulator tone select
// and enable at a programmable bit rate.
//
// Optional feature macro: FSK_SEQ_CRC16_EN
//   defined   -> CRC-16/CCITT (poly 0x1021, init 0xFFFF) appended after payload
//   undefined -> frame ends after the last payload bit
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | modulator off, waiting for start
// ST_PREAMBLE | alternating 1/0 bits, PREAMBLE_BITS long
// ST_SYNC     | SYNC_WORD, MSB first
// ST_PAYLOAD  | payload bytes, MSB first, reloaded from the holding register
// ST_CRC      | CRC-16 trailer, MSB first (only with FSK_SEQ_CRC16_EN)

module fsk_frame_sequencer #(
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'h2DD4,
    parameter int          DIV_W         = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       data,
    input  logic             data_last,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx_en,
    output logic             tone_sel,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
`ifdef FSK_SEQ_CRC16_EN
        ST_PAYLOAD,
        ST_CRC
`else
        ST_PAYLOAD
`endif
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);

    state_t           state;
    logic [DIV_W-1:0] bd_lat;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       bit_cnt;
    // bits still to send after the one currently on tone_sel, MSB next
    logic [14:0]      rem;
    logic             cur_last;
    logic [7:0]       hold_data;
    logic             hold_last;
    logic             hold_full;
    logic             last_seen;
    logic             bit_end;
    logic             accept;

`ifdef FSK_SEQ_CRC16_EN
    logic [15:0]      crc;
    logic [15:0]      crc_nx;
    // CRC advanced by the payload bit currently on tone_sel
    assign crc_nx = {crc[14:0], 1'b0} ^ ((crc[15] ^ tone_sel) ? 16'h1021 : 16'h0000);
`endif

    assign busy       = (state != ST_IDLE);
    assign tx_en      = busy;
    assign bit_end    = (div_cnt == bd_lat);
    assign data_ready = busy & ~hold_full & ~last_seen;
    assign accept     = data_valid & data_ready & ~abort;

    // Frame sequencing, bit timing and the one-byte holding register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ST_IDLE;
            bd_lat    <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            rem       <= '0;
            cur_last  <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            last_seen <= 1'b0;
            tone_sel  <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
`ifdef FSK_SEQ_CRC16_EN
            crc       <= '0;
`endif
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            if (abort) begin
                // abort beats start, bit boundaries and any handshake
                state     <= ST_IDLE;
                tone_sel  <= 1'b0;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                hold_full <= 1'b0;
                last_seen <= 1'b0;
            end else begin
                if (state != ST_IDLE)
                    div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);

                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            bd_lat    <= baud_div;
                            div_cnt   <= '0;
                            bit_cnt   <= '0;
                            tone_sel  <= 1'b1;
                            hold_full <= 1'b0;
                            last_seen <= 1'b0;
`ifdef FSK_SEQ_CRC16_EN
                            crc       <= 16'hFFFF;
`endif
                            state     <= ST_PREAMBLE;
                        end
                    end

                    ST_PREAMBLE: begin
                        if (bit_end) begin
                            if (bit_cnt == PRE_LAST) begin
                                bit_cnt  <= '0;
                                tone_sel <= SYNC_WORD[15];
                                rem      <= SYNC_WORD[14:0];
                                state    <= ST_SYNC;
                            end else begin
                                bit_cnt  <= bit_cnt + 8'd1;
                                tone_sel <= ~tone_sel;
                            end
                        end
                    end

                    ST_SYNC: begin
                        if (bit_end) begin
                            if (bit_cnt == 8'd15) begin
                                bit_cnt <= '0;
                                if (hold_full) begin
                                    tone_sel  <= hold_data[7];
                                    rem       <= {hold_data[6:0], 8'h00};
                                    cur_last  <= hold_last;
                                    hold_full <= 1'b0;
                                    state     <= ST_PAYLOAD;
                                end else begin
                                    tone_sel <= 1'b0;
                                    underrun <= 1'b1;
                                    state    <= ST_IDLE;
                                end
                            end else begin
                                bit_cnt  <= bit_cnt + 8'd1;
                                tone_sel <= rem[14];
                                rem      <= {rem[13:0], 1'b0};
                            end
                        end
                    end

                    ST_PAYLOAD: begin
                        if (bit_end) begin
`ifdef FSK_SEQ_CRC16_EN
                            crc <= crc_nx;
`endif
                            if (bit_cnt == 8'd7) begin
                                bit_cnt <= '0;
                                if (hold_full) begin
                                    // next byte follows with no gap
                                    tone_sel  <= hold_data[7];
                                    rem       <= {hold_data[6:0], 8'h00};
                                    cur_last  <= hold_last;
                                    hold_full <= 1'b0;
                                end else if (cur_last) begin
`ifdef FSK_SEQ_CRC16_EN
                                    tone_sel <= crc_nx[15];
                                    rem      <= crc_nx[14:0];
                                    state    <= ST_CRC;
`else
                                    tone_sel <= 1'b0;
                                    done     <= 1'b1;
                                    state    <= ST_IDLE;
`endif
                                end else begin
                                    tone_sel <= 1'b0;
                                    underrun <= 1'b1;
                                    state    <= ST_IDLE;
                                end
                            end else begin
                                bit_cnt  <= bit_cnt + 8'd1;
                                tone_sel <= rem[14];
                                rem      <= {rem[13:0], 1'b0};
                            end
                        end
                    end

`ifdef FSK_SEQ_CRC16_EN
                    ST_CRC: begin
                        if (bit_end) begin
                            if (bit_cnt == 8'd15) begin
                                bit_cnt  <= '0;
                                tone_sel <= 1'b0;
                                done     <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                bit_cnt  <= bit_cnt + 8'd1;
                                tone_sel <= rem[14];
                                rem      <= {rem[13:0], 1'b0};
                            end
                        end
                    end
`endif

                    default: begin
                        tone_sel <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase

                // placed after the FSM so a same-cycle fill wins over a drain
                if (accept) begin
                    hold_data <= data;
                    hold_last <= data_last;
                    hold_full <= 1'b1;
                    if (data_last)
                        last_seen <= 1'b1;
                end
            end
        end
    end

endmodule
